// File: rtl/shift_right_seq_pkg.sv
// rtl/shift_right_seq_pkg.sv - shared types and constants for the sequential right shifter
//
// Purpose : FSM state encoding, shift-type constants, ALU width constants and
//           the fill-bit helper used by shift_right_seq.
// Contents: XLEN, SHAMT_W, SH_LOGIC, SH_ARITH, state_t, fill_bit()

package shift_right_seq_pkg;

    // ALU width constants (RV32)
    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    // Shift type selected by the arith input
    localparam logic SH_LOGIC = 1'b0;
    localparam logic SH_ARITH = 1'b1;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit shifted in from the top for the whole operation: the operand sign
    // for SRA/SRAI, zero for SRL/SRLI.
    function automatic logic fill_bit(input logic shift_type, input logic msb);
        return (shift_type == SH_ARITH) ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/shift_right_seq.sv
// rtl/shift_right_seq.sv - multi-cycle SRL/SRA unit, one bit per clock
//
// Purpose : Right shifter for the ALU that trades latency for area by
//           shifting the result register one position per clock.
// Ports   :
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only in IDLE
//   A      in   WIDTH  value to shift
//   B      in   SHW    shift amount
//   arith  in   1      1 = sign fill, 0 = zero fill
//   busy   out  1      shift in progress
//   done   out  1      one-cycle pulse, result valid from this cycle on
//   out    out  WIDTH  result, held until the next accepted start

module shift_right_seq
    import shift_right_seq_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int SHW   = SHAMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   B,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             fill_q,  fill_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            count_q <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            count_q <= count_d;
            fill_q  <= fill_d;
        end
    end

    // Next-state and datapath update. Operands are only looked at in IDLE,
    // so changes on A/B/arith while busy cannot disturb a running shift.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        count_d = count_q;
        fill_d  = fill_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    out_d   = A;
                    count_d = B;
                    fill_d  = fill_bit(arith, A[WIDTH-1]);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The count==0 cycle is spent in SHIFT as well, so a shift
                // by B keeps busy high for B+1 cycles.
                if (count_q != '0) begin
                    out_d   = {fill_q, out_q[WIDTH-1:1]};
                    count_d = count_q - SHW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decoded straight from the state register, so busy and done are
    // mutually exclusive and both drop as soon as reset asserts.
    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign out  = out_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// tb/tb_shift_right_seq.sv - directed testbench for shift_right_seq

module tb_shift_right_seq;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] sh_a;
    logic [SHW-1:0]   sh_b;
    logic             arith;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    int tests_run;
    int tests_failed;
    int overlap_cnt;

    shift_right_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (sh_a),
        .B     (sh_b),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // busy and done must never be high together
    always @(negedge clk) begin
        if (busy && done) overlap_cnt++;
    end

    // Apply a one-cycle start pulse; returns #1 after the accepting edge.
    task automatic pulse_start(input logic [WIDTH-1:0] a, input logic [SHW-1:0] b,
                               input logic ar);
        @(posedge clk); #1;
        sh_a  = a;
        sh_b  = b;
        arith = ar;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Run one shift and check result, latency, busy length and done width.
    task automatic run_shift(input string name, input logic [WIDTH-1:0] a,
                             input logic [SHW-1:0] b, input logic ar,
                             input logic [WIDTH-1:0] exp_out);
        int cycles;
        int busy_cnt;
        logic [WIDTH-1:0] res;
        pulse_start(a, b, ar);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            cycles++;
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, cycles);
            return;
        end
        tests_run++;
        if (cycles !== int'(b) + 1) begin
            tests_failed++;
            $display("FAIL %s_latency: %0d edges, required %0d", name, cycles, int'(b) + 1);
        end
        tests_run++;
        if (busy_cnt !== int'(b) + 1) begin
            tests_failed++;
            $display("FAIL %s_busy_len: %0d cycles, required %0d", name, busy_cnt, int'(b) + 1);
        end
        tests_run++;
        if (out !== exp_out) begin
            tests_failed++;
            $display("FAIL %s_out: got %h, required %h", name, out, exp_out);
        end
        res = out;
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== res) begin
            tests_failed++;
            $display("FAIL %s_after_done: done=%b busy=%b out=%h, required 0 0 %h",
                     name, done, busy, out, res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sh_a  = '0;
        sh_b  = '0;
        arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b out=%h, required 0 0 0", busy, done, out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
            tests_failed++;
            $display("FAIL idle_hold: busy=%b done=%b out=%h, required 0 0 0", busy, done, out);
        end
    endtask

    task automatic test_logical();
        run_shift("srl10", 32'h0FFA05FF, 5'd10, 1'b0, 32'h0003FE81);
    endtask

    task automatic test_arith_vs_logical();
        run_shift("sra4", 32'h80000000, 5'd4, 1'b1, 32'hF8000000);
        run_shift("srl4", 32'h80000000, 5'd4, 1'b0, 32'h08000000);
    endtask

    task automatic test_boundaries();
        run_shift("b0",      32'h12345678, 5'd0,  1'b0, 32'h12345678);
        run_shift("sra31",   32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF);
        run_shift("srl31",   32'h80000000, 5'd31, 1'b0, 32'h00000001);
        run_shift("sra_pos", 32'h7000000F, 5'd3,  1'b1, 32'h0E000001);
    endtask

    task automatic test_ignored_start();
        int done_cnt;
        pulse_start(32'hFF000000, 5'd8, 1'b0);
        @(posedge clk); #1;
        // second request in SHIFT with a different operand
        sh_a  = '0;
        sh_b  = 5'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                done_cnt++;
                // request during DONE must also be dropped
                sh_a  = '0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL ignored_start_done_count: %0d pulses, required 1", done_cnt);
        end
        tests_run++;
        if (out !== 32'h00FF0000) begin
            tests_failed++;
            $display("FAIL ignored_start_out: got %h, required %h", out, 32'h00FF0000);
        end
        run_shift("after_ignored", 32'hFF000000, 5'd8, 1'b1, 32'hFFFF0000);
    endtask

    task automatic test_reset_mid_op();
        int done_cnt;
        pulse_start(32'hDEADBEEF, 5'd20, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_op_async: busy=%b done=%b out=%h, required 0 0 0",
                     busy, done, out);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        tests_run++;
        if (done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_op_quiet: %0d busy/done cycles, required 0", done_cnt);
        end
        run_shift("after_reset", 32'h00000100, 5'd8, 1'b0, 32'h00000001);
    endtask

    task automatic test_operand_stability();
        int cycles;
        pulse_start(32'h80000F00, 5'd12, 1'b1);
        cycles = 0;
        while (!done && cycles < 100) begin
            sh_a  = $urandom;
            sh_b  = SHW'($urandom_range(0, 31));
            arith = ~arith;
            @(posedge clk); #1;
            cycles++;
        end
        tests_run++;
        if (cycles !== 13) begin
            tests_failed++;
            $display("FAIL stability_latency: %0d edges, required 13", cycles);
        end
        tests_run++;
        if (out !== 32'hFFF80000) begin
            tests_failed++;
            $display("FAIL stability_out: got %h, required %h", out, 32'hFFF80000);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_invariant();
        tests_run++;
        if (overlap_cnt !== 0) begin
            tests_failed++;
            $display("FAIL busy_done_overlap: %0d cycles, required 0", overlap_cnt);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        overlap_cnt  = 0;
        test_reset();
        test_logical();
        test_arith_vs_logical();
        test_boundaries();
        test_ignored_start();
        test_reset_mid_op();
        test_operand_stability();
        test_invariant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
